// File: rtl/count6_ctrl.sv
// Sequencing controller for one count_6 mod-6 counter: clear, run N laps, pause/abort, done pulse.
// Optional watchdog on missing carry-out enabled by defining COUNT6_CTRL_WDOG_EN.
module count6_ctrl #(
  parameter int unsigned LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LAP_W-1:0] laps,
  input  logic             pause,
  input  logic             abort,
  input  logic             cnt_co,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LAP_W-1:0] laps_q;
  logic [LAP_W-1:0] laps_q_nxt;
  logic [LAP_W-1:0] lap_cnt_nxt;
  logic [LAP_W-1:0] lap_cnt_inc;
  logic             start_acc;
  logic             lap_inc;
  logic             wdog_trip;

  // Output decode is combinational from state; cnt_en follows pause in the same cycle.
  always_comb begin
    cnt_rst = (state == S_CLEAR);
    cnt_en  = (state == S_RUN) & ~pause;
    busy    = (state == S_CLEAR) | (state == S_RUN);
    done    = (state == S_DONE);
  end

  assign start_acc   = (state == S_IDLE) & start & (laps != '0);
  assign lap_inc     = (state == S_RUN) & cnt_en & cnt_co;
  assign lap_cnt_inc = LAP_W'(lap_cnt + LAP_W'(1));

`ifdef COUNT6_CTRL_WDOG_EN
  logic [2:0] wdog_q;

  // Counts consecutive enabled RUN cycles without a carry-out; trips on the sixth.
  assign wdog_trip = (state == S_RUN) & cnt_en & ~cnt_co & (wdog_q == 3'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= 3'd0;
      err    <= 1'b0;
    end else begin
      if (state != S_RUN || cnt_co) begin
        wdog_q <= 3'd0;
      end else if (cnt_en) begin
        wdog_q <= 3'(wdog_q + 3'd1);
      end
      if (start_acc) begin
        err <= 1'b0;
      end else if (wdog_trip) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    laps_q_nxt  = laps_q;
    lap_cnt_nxt = lap_cnt;
    case (state)
      S_IDLE: begin
        if (start_acc) begin
          state_nxt   = S_CLEAR;
          laps_q_nxt  = laps;
          lap_cnt_nxt = '0;
        end
      end
      S_CLEAR: begin
        state_nxt = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // abort wins over lap completion and leaves lap_cnt untouched
        if (abort || wdog_trip) begin
          state_nxt = S_IDLE;
        end else if (lap_inc) begin
          lap_cnt_nxt = lap_cnt_inc;
          if (lap_cnt_inc == laps_q) begin
            state_nxt = S_DONE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      laps_q  <= '0;
      lap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      laps_q  <= laps_q_nxt;
      lap_cnt <= lap_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_count6_ctrl.sv
// Directed bench for count6_ctrl with a behavioral count_6 model closing the loop.
module tb_count6_ctrl;

  localparam int unsigned LAP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LAP_W-1:0] laps;
  logic             pause;
  logic             abort;
  logic             cnt_co;
  logic             cnt_rst;
  logic             cnt_en;
  logic             busy;
  logic             done;
  logic [LAP_W-1:0] lap_cnt;
  logic             err;

  logic [2:0] cnt6 = 3'd3;
  logic       kill_co = 1'b0;

  int nchk = 0;
  int nfail = 0;

  count6_ctrl #(.LAP_W(LAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .laps(laps), .pause(pause),
    .abort(abort), .cnt_co(cnt_co), .cnt_rst(cnt_rst), .cnt_en(cnt_en),
    .busy(busy), .done(done), .lap_cnt(lap_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Reference count_6 counter; starts at a nonzero value so CLEAR has to matter.
  always @(posedge clk) begin
    if (cnt_rst)     cnt6 <= 3'd0;
    else if (cnt_en) cnt6 <= (cnt6 == 3'd5) ? 3'd0 : 3'(cnt6 + 3'd1);
  end
  assign cnt_co = (cnt6 == 3'd5) & ~kill_co;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start a run, then step cycles 1..budget (cycle i lies between edges E(i-1) and Ei).
  // Returns the edge index at which done was first seen (-1 if never) and enable/clear cycle counts.
  task automatic run(input int lv, input int budget, input int pf, input int pl,
                     input int ab, input int sa,
                     output int t_done, output int en_c, output int rst_c, output int en_in_pause);
    t_done = -1; en_c = 0; rst_c = 0; en_in_pause = 0;
    start = 1'b1; laps = LAP_W'(lv);
    tick();
    start = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      pause = (i >= pf) && (i < pf + pl);
      abort = (i == ab);
      if (i == sa) begin
        start = 1'b1; laps = 8'd7;
      end else begin
        start = 1'b0;
      end
      #1;
      if (cnt_en) en_c++;
      if (cnt_rst) rst_c++;
      if (cnt_en && pause) en_in_pause++;
      tick();
      if (done) begin
        t_done = i;
        break;
      end
    end
    pause = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  int t_done, en_c, rst_c, enp;

  initial begin
    rst = 1'b1; start = 1'b0; laps = '0; pause = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_cnt_en", int'(cnt_en), 0);
    check("reset_cnt_rst", int'(cnt_rst), 0);
    check("reset_lap_cnt", int'(lap_cnt), 0);
    check("reset_err", int'(err), 0);

    // laps=2 basic run
    run(2, 40, 0, 0, 0, 0, t_done, en_c, rst_c, enp);
    check("l2_done_edge", t_done, 13);
    check("l2_en_cycles", en_c, 12);
    check("l2_clr_cycles", rst_c, 1);
    check("l2_lap_cnt", int'(lap_cnt), 2);
    check("l2_counter", int'(cnt6), 0);
    check("l2_busy_in_done", int'(busy), 0);
    tick();
    check("l2_done_one_cycle", int'(done), 0);

    // laps=1 with 3 pause cycles mid-run
    run(1, 40, 4, 3, 0, 0, t_done, en_c, rst_c, enp);
    check("pause_done_edge", t_done, 10);
    check("pause_en_cycles", en_c, 6);
    check("pause_en_low", enp, 0);
    check("pause_lap_cnt", int'(lap_cnt), 1);
    tick();

    // laps=3 aborted in the 8th RUN cycle
    run(3, 30, 0, 0, 9, 0, t_done, en_c, rst_c, enp);
    check("abort_no_done", t_done, -1);
    check("abort_en_cycles", en_c, 8);
    check("abort_lap_cnt", int'(lap_cnt), 1);
    check("abort_busy", int'(busy), 0);

    // start with laps=0 is ignored
    start = 1'b1; laps = '0;
    tick();
    check("z_busy", int'(busy), 0);
    check("z_cnt_rst", int'(cnt_rst), 0);
    tick();
    check("z_cnt_en", int'(cnt_en), 0);
    check("z_busy2", int'(busy), 0);
    start = 1'b0;

    // start with laps=7 during RUN must not disturb a laps=2 run
    run(2, 40, 0, 0, 0, 5, t_done, en_c, rst_c, enp);
    check("busy_start_done_edge", t_done, 13);
    check("busy_start_lap_cnt", int'(lap_cnt), 2);
    tick(); tick();
    check("busy_start_idle", int'(busy), 0);

    // reset mid-RUN, then a clean laps=1 run
    run(2, 10, 0, 0, 0, 0, t_done, en_c, rst_c, enp);
    check("mid_lap_cnt", int'(lap_cnt), 1);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_cnt_en", int'(cnt_en), 0);
    check("rst_lap_cnt", int'(lap_cnt), 0);
    check("rst_done", int'(done), 0);
    run(1, 40, 0, 0, 0, 0, t_done, en_c, rst_c, enp);
    check("after_rst_done_edge", t_done, 7);
    check("after_rst_en_cycles", en_c, 6);
    check("after_rst_lap_cnt", int'(lap_cnt), 1);
    tick();

`ifdef COUNT6_CTRL_WDOG_EN
    // carry-out stuck low trips the watchdog
    kill_co = 1'b1;
    run(1, 30, 0, 0, 0, 0, t_done, en_c, rst_c, enp);
    check("wdog_no_done", t_done, -1);
    check("wdog_en_cycles", en_c, 6);
    check("wdog_err", int'(err), 1);
    check("wdog_busy", int'(busy), 0);
    kill_co = 1'b0;
    run(1, 40, 0, 0, 0, 0, t_done, en_c, rst_c, enp);
    check("wdog_clr_err", int'(err), 0);
    check("wdog_rerun_done", t_done, 7);
`else
    check("no_wdog_err", int'(err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
